// File: rtl/event_encoder.sv
// event_encoder: registered 8-to-3 event encoder with sticky pending requests.
// Request pulses on d0..d7 are captured into a pending vector; the highest
// pending index is presented on {a,b,c} with valid and held until ack.
module event_encoder (
   input  logic       clk,
   input  logic       reset,
   input  logic       d0,
   input  logic       d1,
   input  logic       d2,
   input  logic       d3,
   input  logic       d4,
   input  logic       d5,
   input  logic       d6,
   input  logic       d7,
   input  logic       ack,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       valid,
   output logic [7:0] pending,
   output logic       overrun
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  code_q, code_d;
   logic [7:0]  pend_q, pend_d;
   logic        ovr_q, ovr_d;

   logic [7:0]  req;
   logic [7:0]  clr;
   logic        accept;

   // Highest set index of a request vector; zero when the vector is empty.
   function automatic logic [2:0] top_index(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   assign req    = {d7, d6, d5, d4, d3, d2, d1, d0};
   assign accept = (state_q == PRESENT) && ack;

   // Next pending/code/state: the acked bit is cleared, new requests are ORed
   // in afterwards so a request on the bit being cleared re-sets it.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      code_d  = code_q;
      clr     = 8'h00;
      if (accept) clr = 8'h01 << code_q;
      pend_d  = (pend_q & ~clr) | req;
      ovr_d   = ovr_q | (|(req & pend_q & ~clr));
      case (state_q)
         IDLE: begin
            if (pend_d != 8'h00) begin
               code_d  = top_index(pend_d);
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            // Without ack the presented code is frozen; newer requests only queue.
            if (ack) begin
               code_d  = top_index(pend_d);
               state_d = (pend_d != 8'h00) ? PRESENT : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset taking priority over all inputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (reset) begin
         state_q <= IDLE;
         code_q  <= 3'd0;
         pend_q  <= 8'h00;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
      end
   end

   assign {a, b, c} = code_q;
   assign valid     = (state_q == PRESENT);
   assign pending   = pend_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_event_encoder.sv
// Directed self-checking bench for event_encoder; expected values are
// hand-computed constants for each step.
module tb_event_encoder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] d;
   logic       ack;
   logic       a, b, c, valid, overrun;
   logic [7:0] pending;

   int checks = 0;
   int errors = 0;

   event_encoder dut (
      .clk     (clk),
      .reset   (reset),
      .d0      (d[0]),
      .d1      (d[1]),
      .d2      (d[2]),
      .d3      (d[3]),
      .d4      (d[4]),
      .d5      (d[5]),
      .d6      (d[6]),
      .d7      (d[7]),
      .ack     (ack),
      .a       (a),
      .b       (b),
      .c       (c),
      .valid   (valid),
      .pending (pending),
      .overrun (overrun)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply current inputs across one rising edge; sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic v, input logic [2:0] abc,
                            input logic [7:0] p, input logic o);
      check({tag, ".valid"},   {7'd0, valid}, {7'd0, v});
      if (v) check({tag, ".abc"}, {5'd0, a, b, c}, {5'd0, abc});
      check({tag, ".pending"}, pending, p);
      check({tag, ".overrun"}, {7'd0, overrun}, {7'd0, o});
   endtask

   initial begin
      // Reset dominates all-ones requests and ack for two edges.
      reset = 1'b1; d = 8'hFF; ack = 1'b1;
      step();
      step();
      check_all("rst", 1'b0, 3'd0, 8'h00, 1'b0);
      check("rst.abc", {5'd0, a, b, c}, 8'h00);

      // Release reset with all requests still high: all captured, 7 presented.
      reset = 1'b0;
      step();
      check_all("rel", 1'b1, 3'd7, 8'hFF, 1'b0);

      // Hold ack: one code per cycle, descending, no bubbles.
      d = 8'h00;
      for (int n = 6; n >= 0; n--) begin
         step();
         check_all($sformatf("drain%0d", n), 1'b1, 3'(n), 8'hFF >> (7 - n), 1'b0);
      end
      step();
      check_all("drain_end", 1'b0, 3'd0, 8'h00, 1'b0);

      // ack while idle is ignored.
      step();
      check_all("idle_ack", 1'b0, 3'd0, 8'h00, 1'b0);
      ack = 1'b0;

      // Single event per line.
      for (int n = 0; n < 8; n++) begin
         d = 8'h01 << n; ack = 1'b0;
         step();
         check_all($sformatf("single%0d", n), 1'b1, 3'(n), 8'h01 << n, 1'b0);
         d = 8'h00; ack = 1'b1;
         step();
         check_all($sformatf("single%0d_ack", n), 1'b0, 3'd0, 8'h00, 1'b0);
      end

      // Burst priority: d1,d4,d6 together then continuous ack.
      d = 8'h52; ack = 1'b0;
      step();
      check_all("burst0", 1'b1, 3'd6, 8'h52, 1'b0);
      d = 8'h00; ack = 1'b1;
      step();
      check_all("burst1", 1'b1, 3'd4, 8'h12, 1'b0);
      step();
      check_all("burst2", 1'b1, 3'd1, 8'h02, 1'b0);
      step();
      check_all("burst3", 1'b0, 3'd0, 8'h00, 1'b0);

      // No pre-emption by a higher request.
      d = 8'h04; ack = 1'b0;
      step();
      check_all("npe0", 1'b1, 3'd2, 8'h04, 1'b0);
      d = 8'h80;
      step();
      check_all("npe1", 1'b1, 3'd2, 8'h84, 1'b0);
      d = 8'h00; ack = 1'b1;
      step();
      check_all("npe2", 1'b1, 3'd7, 8'h80, 1'b0);
      step();
      check_all("npe3", 1'b0, 3'd0, 8'h00, 1'b0);

      // Same-bit set and clear: set wins, no overrun.
      d = 8'h08; ack = 1'b0;
      step();
      check_all("same0", 1'b1, 3'd3, 8'h08, 1'b0);
      ack = 1'b1;
      step();
      check_all("same1", 1'b1, 3'd3, 8'h08, 1'b0);
      d = 8'h00;
      step();
      check_all("same2", 1'b0, 3'd0, 8'h00, 1'b0);

      // Overrun: repeat d5 while pending, sticky through later traffic.
      d = 8'h20; ack = 1'b0;
      step();
      check_all("ovr0", 1'b1, 3'd5, 8'h20, 1'b0);
      step();
      check_all("ovr1", 1'b1, 3'd5, 8'h20, 1'b1);
      d = 8'h00; ack = 1'b1;
      step();
      check_all("ovr2", 1'b0, 3'd0, 8'h00, 1'b1);
      d = 8'h01; ack = 1'b0;
      step();
      check_all("ovr3", 1'b1, 3'd0, 8'h01, 1'b1);
      d = 8'h00; ack = 1'b1;
      step();
      check_all("ovr4", 1'b0, 3'd0, 8'h00, 1'b1);

      // Mid-operation reset discards pending work and overrun.
      d = 8'h30; ack = 1'b0;
      step();
      check_all("mid0", 1'b1, 3'd5, 8'h30, 1'b1);
      reset = 1'b1; d = 8'h02;
      step();
      check_all("mid_rst", 1'b0, 3'd0, 8'h00, 1'b0);
      check("mid_rst.abc", {5'd0, a, b, c}, 8'h00);
      reset = 1'b0;
      step();
      check_all("mid_resume", 1'b1, 3'd1, 8'h02, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/event_encoder.md
# event_encoder

Registered 8-to-3 event encoder with a pending-request register and a valid/ack handshake, the sequential counterpart of the team's 3-to-8 decoder. Single-cycle pulses on eight request lines d0..d7 are captured as sticky pending bits. The index of the highest-priority pending request is presented on a/b/c (a = MSB) with valid, and held until the consumer acknowledges it. This lets interrupt-style event sources feed a consumer that can only take one 3-bit code at a time.

## Interface
- No parameters; width fixed at 8 requests / 3-bit code.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- d0..d7  in  1 each  request lines; dN high at an edge raises request N
- ack  in  1  consumer accepts the presented code
- a, b, c  out  1 each  registered code of the presented request; {a,b,c} = N (a = bit 2, c = bit 0)
- valid  out  1  registered; {a,b,c} holds a pending request
- pending  out  8  registered pending vector; bit N = request N outstanding
- overrun  out  1  registered sticky flag: a request arrived while already pending

## Operation
- Only one clock and a synchronous active-high reset. Reset has priority over every other input at an edge.
- Reset values: pending = 8'h00, valid = 0, a = b = c = 0, overrun = 0.
- Priority: highest index wins (d7 over d6 ... over d0).
- Clear mask: clr = one-hot({a,b,c}) when valid && ack at the edge, else 0.
- Next pending: pend_next = (pending & ~clr) | {d7..d0}. A request arriving on the same bit being cleared re-sets it (set wins), so the event is not lost.
- Two states, implied by valid:
  - IDLE (valid = 0): at each edge, if pend_next != 0, load {a,b,c} = highest set index of pend_next and go to PRESENT (valid = 1). Otherwise stay in IDLE.
  - PRESENT (valid = 1, ack = 0): {a,b,c} and valid are frozen. A newly arriving higher-priority request only sets its pending bit and does not pre-empt.
  - PRESENT, ack = 1: the acked bit is cleared. {a,b,c} reloads with the highest index of pend_next. valid = (pend_next != 0), so back-to-back codes have no bubble.
- ack while valid = 0 is ignored; no state change beyond normal request capture.
- overrun is set at an edge where any dN = 1 and pending[N] = 1 and clr[N] = 0. It is cleared only by reset.
- pending, valid, {a,b,c} and overrun are all registers. No output is a combinational function of inputs.

## Timing
- Request latency: dN high before edge k → pending[N] = 1 and, if idle, valid = 1 with {a,b,c} = N after edge k (one cycle).
- Ack latency: valid && ack at edge k → pending bit cleared and the next code (or valid = 0) after edge k.
- Sustained throughput: one code per cycle when ack is held high and requests are pending.
- Code stability: {a,b,c} changes only on an acked edge, a reset edge, or an IDLE→PRESENT edge.
- Reset mid-operation: reset at edge k drops all pending requests and the presented code, and clears overrun. Requests present at edge k are discarded. Capture resumes at edge k+1.
- Simultaneous requests on several lines at one edge are all captured. They are presented in descending index order over successive acks.

## Test plan
- Reset: drive all d = 1 and ack = 1 with reset = 1 for 2 edges → pending = 00, valid = 0, abc = 000, overrun = 0. Deassert reset → after the next edge pending = FF, abc = 111.
- Single event per line: for N = 0..7, pulse dN for one cycle with ack = 0. Required: after that edge valid = 1 and abc = N. Ack one cycle, after which valid = 0 and pending = 00.
- Burst priority: pulse d1, d4, d6 together, then hold ack = 1. Required: abc = 110, 100, 001 on three consecutive cycles, then valid = 0, with no bubble cycles.
- No pre-emption: pulse d2 and let abc = 010 present with ack = 0. Pulse d7 → abc stays 010 and pending = 84. Ack → abc = 111.
- Same-bit set/clear: with abc = 011 presented, assert ack and d3 at the same edge. Required: valid = 1, abc = 011, pending = 08, overrun = 0.
- Overrun: with pending[5] = 1 and ack = 0, pulse d5 → overrun = 1 after that edge, and pending unchanged (20). overrun remains 1 through later acks until reset.
